// File: rtl/snn_lif_layer_pkg.sv
// ----------------------------------------------------------------------------
// snn_lif_layer_pkg : shared state encodings, address map and saturating add
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package snn_lif_layer_pkg;

   typedef enum logic [1:0] {
      SNN_ST_IDLE   = 2'd0,
      SNN_ST_ACCUM  = 2'd1,
      SNN_ST_UPDATE = 2'd2
   } snn_state_t;

   // Config registers sit directly above the N_IN*N_OUT weight entries
   localparam int unsigned c_ofs_thr    = 0;
   localparam int unsigned c_ofs_leak   = 1;
   localparam int unsigned c_ofs_refrac = 2;

   // v - leak_term + acc, clamped to the signed range of a v_w-bit potential
   function automatic logic signed [31:0] sat_add(
      input logic signed [31:0] v,
      input logic signed [31:0] leak_term,
      input logic signed [31:0] acc,
      input int unsigned        v_w
   );
      logic signed [31:0] sum;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi  = (32'sd1 <<< (v_w - 1)) - 32'sd1;
      lo  = -hi - 32'sd1;
      sum = v - leak_term + acc;
      if (sum > hi) begin
         return hi;
      end else if (sum < lo) begin
         return lo;
      end
      return sum;
   endfunction

endpackage

`default_nettype wire

// File: rtl/snn_lif_layer_if.sv
// ----------------------------------------------------------------------------
// snn_lif_layer_if : step / spike / config bundle of the LIF layer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface snn_lif_layer_if #(
   parameter int N_IN  = 8,
   parameter int N_OUT = 2,
   parameter int V_W   = 8
);
   localparam int c_addr_w = $clog2(N_IN * N_OUT + 3);

   logic                step;
   logic [N_IN-1:0]     in_spikes;
   logic                busy;
   logic                out_valid;
   logic [N_OUT-1:0]    out_spikes;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [c_addr_w-1:0] cfg_addr;
   logic [V_W-1:0]      cfg_data;

   modport master (
      output step, in_spikes, cfg_valid, cfg_addr, cfg_data,
      input  busy, out_valid, out_spikes, cfg_ready
   );

   modport slave (
      input  step, in_spikes, cfg_valid, cfg_addr, cfg_data,
      output busy, out_valid, out_spikes, cfg_ready
   );

endinterface

`default_nettype wire

// File: rtl/snn_lif_layer_neuron.sv
// ----------------------------------------------------------------------------
// snn_lif_layer_neuron : one LIF neuron - input accumulator, membrane, refractory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module snn_lif_layer_neuron
   import snn_lif_layer_pkg::*;
#(
   parameter int N_IN = 8,
   parameter int W_W  = 4,
   parameter int V_W  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           add_en,
   input  logic [W_W-1:0] w,
   input  logic           update,
   input  logic [V_W-1:0] thr,
   input  logic [2:0]     leak_sh,
   input  logic [3:0]     refrac,
   output logic           spike
);
   // Wide enough that N_IN extreme weights can never overflow
   localparam int c_acc_w = V_W + $clog2(N_IN);

   logic signed [V_W-1:0]     r_v;
   logic        [3:0]         r_rc;
   logic signed [c_acc_w-1:0] r_acc;

   logic signed [31:0] w_v_ext;
   logic signed [31:0] w_leak;
   logic signed [31:0] w_acc_ext;
   logic signed [31:0] w_thr_ext;
   logic signed [31:0] w_vn;

   assign w_v_ext   = {{(32 - V_W){r_v[V_W-1]}}, r_v};
   // leak_sh = 0 makes the leak equal to v, i.e. a full leak
   assign w_leak    = w_v_ext >>> leak_sh;
   assign w_acc_ext = {{(32 - c_acc_w){r_acc[c_acc_w-1]}}, r_acc};
   assign w_thr_ext = {{(32 - V_W){thr[V_W-1]}}, thr};
   assign w_vn      = sat_add(w_v_ext, w_leak, w_acc_ext, V_W);

   assign spike = (r_rc == 4'd0) && (w_vn >= w_thr_ext);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v   <= '0;
         r_rc  <= '0;
         r_acc <= '0;
      end else begin
         if (clr) begin
            r_acc <= '0;
         end else if (add_en) begin
            r_acc <= r_acc + {{(c_acc_w - W_W){w[W_W-1]}}, w};
         end

         if (update) begin
            if (r_rc != 4'd0) begin
               r_rc <= r_rc - 4'd1;
               r_v  <= '0;
            end else if (spike) begin
               r_v  <= '0;
               r_rc <= refrac;
            end else begin
               r_v  <= w_vn[V_W-1:0];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/snn_lif_layer.sv
// ----------------------------------------------------------------------------
// snn_lif_layer : N_IN x N_OUT leaky-integrate-and-fire layer, serial input scan
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module snn_lif_layer
   import snn_lif_layer_pkg::*;
#(
   parameter int N_IN    = 8,
   parameter int N_OUT   = 2,
   parameter int W_W     = 4,
   parameter int V_W     = 8,
   parameter int THR_RST = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   snn_lif_layer_if.slave bus
);
   localparam int c_n_wgt  = N_IN * N_OUT;
   localparam int c_addr_w = $clog2(c_n_wgt + 3);
   localparam int c_idx_w  = (N_IN > 1) ? $clog2(N_IN) : 1;

   snn_state_t r_state;
   snn_state_t w_state_next;

   logic [c_idx_w-1:0] r_idx;
   logic [N_IN-1:0]    r_spk_q;
   logic [W_W-1:0]     r_weight [N_OUT][N_IN];
   logic [V_W-1:0]     r_thr;
   logic [2:0]         r_leak_sh;
   logic [3:0]         r_refrac;
   logic               r_out_valid;
   logic [N_OUT-1:0]   r_out_spikes;

   logic               w_busy;
   logic               w_accept;
   logic               w_cfg_we;
   logic               w_last;
   logic               w_spk_bit;
   logic               w_clr;
   logic               w_add_en;
   logic               w_update;
   logic [N_OUT-1:0]   w_spike;

   // The out_valid cycle still counts as busy, so a held step cannot re-arm early
   assign w_busy   = (r_state != SNN_ST_IDLE) || r_out_valid;
   assign w_accept = (r_state == SNN_ST_IDLE) && !r_out_valid && bus.step;
   assign w_cfg_we = bus.cfg_valid && !w_busy;
   assign w_last   = (r_idx == c_idx_w'(N_IN - 1));

   assign bus.busy       = w_busy;
   assign bus.cfg_ready  = !w_busy;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_spikes = r_out_spikes;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= SNN_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_clr        = 1'b0;
      w_add_en     = 1'b0;
      w_update     = 1'b0;
      case (r_state)
         SNN_ST_IDLE: begin
            if (w_accept) begin
               w_clr        = 1'b1;
               w_state_next = SNN_ST_ACCUM;
            end
         end
         SNN_ST_ACCUM: begin
            w_add_en = w_spk_bit;
            if (w_last) begin
               w_state_next = SNN_ST_UPDATE;
            end
         end
         SNN_ST_UPDATE: begin
            w_update     = 1'b1;
            w_state_next = SNN_ST_IDLE;
         end
         default: begin
            w_state_next = SNN_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx        <= '0;
         r_spk_q      <= '0;
         r_out_valid  <= 1'b0;
         r_out_spikes <= '0;
      end else begin
         r_out_valid <= w_update;
         if (w_accept) begin
            r_spk_q <= bus.in_spikes;
            r_idx   <= '0;
         end else if (r_state == SNN_ST_ACCUM) begin
            r_idx <= r_idx + c_idx_w'(1);
         end
         if (w_update) begin
            r_out_spikes <= w_spike;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_thr     <= V_W'(THR_RST);
         r_leak_sh <= 3'd3;
         r_refrac  <= 4'd0;
         for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
               r_weight[o][i] <= '0;
            end
         end
      end else if (w_cfg_we) begin
         for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
               if (bus.cfg_addr == c_addr_w'(o * N_IN + i)) begin
                  r_weight[o][i] <= bus.cfg_data[W_W-1:0];
               end
            end
         end
         if (bus.cfg_addr == c_addr_w'(c_n_wgt + c_ofs_thr)) begin
            r_thr <= bus.cfg_data;
         end
         if (bus.cfg_addr == c_addr_w'(c_n_wgt + c_ofs_leak)) begin
            r_leak_sh <= bus.cfg_data[2:0];
         end
         if (bus.cfg_addr == c_addr_w'(c_n_wgt + c_ofs_refrac)) begin
            r_refrac <= bus.cfg_data[3:0];
         end
      end
   end

   always_comb begin
      w_spk_bit = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
         if (r_idx == c_idx_w'(i)) begin
            w_spk_bit = r_spk_q[i];
         end
      end
   end

   for (genvar o = 0; o < N_OUT; o++) begin : g_neuron
      logic [W_W-1:0] w_wsel;

      always_comb begin
         w_wsel = '0;
         for (int i = 0; i < N_IN; i++) begin
            if (r_idx == c_idx_w'(i)) begin
               w_wsel = r_weight[o][i];
            end
         end
      end

      snn_lif_layer_neuron #(
         .N_IN (N_IN),
         .W_W  (W_W),
         .V_W  (V_W)
      ) u_neuron (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (w_clr),
         .add_en  (w_add_en),
         .w       (w_wsel),
         .update  (w_update),
         .thr     (r_thr),
         .leak_sh (r_leak_sh),
         .refrac  (r_refrac),
         .spike   (w_spike[o])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_snn_lif_layer.sv
// ----------------------------------------------------------------------------
// tb_snn_lif_layer : directed vector bench for an 8x2 and a 3x4 LIF layer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_snn_lif_layer;

   typedef struct {
      bit         is_step;
      logic [4:0] addr;
      logic [7:0] data;
      logic [1:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_pass;
   int   n_total;
   vec_t tbl[$];

   always #5 clk = ~clk;

   snn_lif_layer_if #(.N_IN(8), .N_OUT(2), .V_W(8)) m_bus ();
   snn_lif_layer_if #(.N_IN(3), .N_OUT(4), .V_W(8)) s_bus ();

   snn_lif_layer #(
      .N_IN(8), .N_OUT(2), .W_W(4), .V_W(8), .THR_RST(32)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m_bus)
   );

   snn_lif_layer #(
      .N_IN(3), .N_OUT(4), .W_W(4), .V_W(8), .THR_RST(32)
   ) u_dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (s_bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add_cfg(input logic [4:0] a, input logic [7:0] d);
      vec_t v;
      v.is_step = 1'b0;
      v.addr    = a;
      v.data    = d;
      v.exp     = 2'b00;
      tbl.push_back(v);
   endfunction

   function automatic void add_step(input logic [7:0] spk, input logic [1:0] e);
      vec_t v;
      v.is_step = 1'b1;
      v.addr    = 5'd0;
      v.data    = spk;
      v.exp     = e;
      tbl.push_back(v);
   endfunction

   task automatic m_idle();
      int n = 0;
      while (m_bus.busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (m_bus.busy) check("m_idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic m_cfg(input logic [4:0] a, input logic [7:0] d);
      int n = 0;
      m_bus.cfg_valid = 1'b1;
      m_bus.cfg_addr  = a;
      m_bus.cfg_data  = d;
      while (!m_bus.cfg_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!m_bus.cfg_ready) check("m_cfg_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      m_bus.cfg_valid = 1'b0;
   endtask

   // lat counts edges from the accepting edge (1) to the one raising out_valid
   task automatic m_step(input logic [7:0] spk, output logic [1:0] outs, output int lat);
      m_idle();
      m_bus.in_spikes = spk;
      m_bus.step      = 1'b1;
      @(posedge clk); #1;
      m_bus.step      = 1'b0;
      m_bus.in_spikes = '0;
      lat = 1;
      while (!m_bus.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      outs = m_bus.out_spikes;
   endtask

   task automatic s_cfg(input logic [3:0] a, input logic [7:0] d);
      int n = 0;
      s_bus.cfg_valid = 1'b1;
      s_bus.cfg_addr  = a;
      s_bus.cfg_data  = d;
      while (!s_bus.cfg_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!s_bus.cfg_ready) check("s_cfg_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      s_bus.cfg_valid = 1'b0;
   endtask

   task automatic s_step(input logic [2:0] spk, output logic [3:0] outs, output int lat);
      int n = 0;
      while (s_bus.busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      s_bus.in_spikes = spk;
      s_bus.step      = 1'b1;
      @(posedge clk); #1;
      s_bus.step      = 1'b0;
      s_bus.in_spikes = '0;
      lat = 1;
      while (!s_bus.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      outs = s_bus.out_spikes;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] outs;
      logic [3:0] souts;
      logic [1:0] ov_spk;
      logic [3:0] s_exp [7];
      int         lat;
      int         n;
      int         ov_n;
      int         pulses;
      int         p1;
      int         p2;

      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      m_bus.step = 1'b0; m_bus.in_spikes = '0; m_bus.cfg_valid = 1'b0;
      m_bus.cfg_addr = '0; m_bus.cfg_data = '0;
      s_bus.step = 1'b0; s_bus.in_spikes = '0; s_bus.cfg_valid = 1'b0;
      s_bus.cfg_addr = '0; s_bus.cfg_data = '0;

      // Main 8x2 vectors; addr 0..15 weights, 16 thr, 17 leak_sh, 18 refrac
      add_cfg(5'd0, 8'd7);  add_cfg(5'd17, 8'd7);
      for (int k = 0; k < 4; k++) add_step(8'h01, 2'b00);
      add_step(8'h01, 2'b01);                          // 35 >= default thr 32
      add_cfg(5'd16, 8'd20); add_cfg(5'd17, 8'd0);
      for (int k = 0; k < 3; k++) add_step(8'h01, 2'b00);  // full leak: v stays 7
      add_cfg(5'd17, 8'd7);
      add_step(8'h01, 2'b00); add_step(8'h01, 2'b01); add_step(8'h01, 2'b00);
      add_cfg(5'd1, 8'd5);  add_cfg(5'd17, 8'd1);
      add_step(8'h03, 2'b00); add_step(8'h03, 2'b01);  // 7-3+12=16, 16-8+12=20
      add_step(8'h02, 2'b00); add_step(8'hFC, 2'b00);  // 5, then 5-2+0=3
      for (int k = 0; k < 8; k++) add_cfg(5'(8 + k), 8'd7);
      add_cfg(5'd16, 8'd127); add_cfg(5'd17, 8'd7);
      add_step(8'hFF, 2'b00); add_step(8'hFF, 2'b00); add_step(8'hFF, 2'b10); // 56,112,sat 127
      add_cfg(5'd18, 8'd2); add_cfg(5'd16, 8'd20);
      add_step(8'hFF, 2'b11); add_step(8'hFF, 2'b00); add_step(8'hFF, 2'b00);
      add_step(8'hFF, 2'b10); add_step(8'hFF, 2'b01); add_step(8'hFF, 2'b00);
      add_cfg(5'd18, 8'd0); add_step(8'h00, 2'b00);
      add_cfg(5'd16, 8'hFB);                           // thr = -5
      add_step(8'h00, 2'b11); add_step(8'h00, 2'b11);

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",       32'(m_bus.busy),       32'd0);
      check("rst_out_valid",  32'(m_bus.out_valid),  32'd0);
      check("rst_out_spikes", 32'(m_bus.out_spikes), 32'd0);
      check("rst_cfg_ready",  32'(m_bus.cfg_ready),  32'd1);
      rst_n = 1'b1;

      // Make out_spikes nonzero, then reset in the middle of ACCUM
      m_cfg(5'd16, 8'hFB);
      m_step(8'h00, outs, lat);
      check("pre_rst_spikes", 32'(outs), 32'd3);
      check("pre_rst_lat",    32'(lat),  32'd10);
      m_idle();
      m_bus.step = 1'b1;
      @(posedge clk); #1;
      m_bus.step = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid_accum_busy", 32'(m_bus.busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_busy",       32'(m_bus.busy),       32'd0);
      check("abort_out_valid",  32'(m_bus.out_valid),  32'd0);
      check("abort_out_spikes", 32'(m_bus.out_spikes), 32'd0);
      pulses = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (m_bus.out_valid) pulses++;
      end
      check("abort_no_pulse", 32'(pulses), 32'd0);

      foreach (tbl[k]) begin
         if (!tbl[k].is_step) begin
            m_cfg(tbl[k].addr, tbl[k].data);
         end else begin
            m_step(tbl[k].data, outs, lat);
            check($sformatf("vec%0d_spikes", k), 32'(outs), 32'(tbl[k].exp));
            check($sformatf("vec%0d_lat", k),    32'(lat),  32'd10);
         end
      end

      // step held high: one out_valid every N_IN+3 = 11 cycles
      m_idle();
      m_bus.step = 1'b1;
      pulses = 0; p1 = 0; p2 = 0;
      for (int c = 1; c <= 34; c++) begin
         @(posedge clk); #1;
         if (m_bus.out_valid) begin
            pulses++;
            if (pulses == 1) p1 = c;
            else if (pulses == 2) p2 = c;
         end
      end
      m_bus.step = 1'b0;
      check("held_pulses", 32'(pulses), 32'd3);
      check("held_first",  32'(p1),     32'd10);
      check("held_second", 32'(p2),     32'd21);

      // Config request raised while busy waits for busy to fall
      m_idle();
      m_bus.step = 1'b1;
      @(posedge clk); #1;
      m_bus.step      = 1'b0;
      m_bus.cfg_valid = 1'b1;
      m_bus.cfg_addr  = 5'd16;
      m_bus.cfg_data  = 8'd100;
      check("cfg_ready_busy", 32'(m_bus.cfg_ready), 32'd0);
      n = 1; ov_n = 0; ov_spk = 2'b00;
      while (!m_bus.cfg_ready && n < 50) begin
         if (m_bus.out_valid) begin
            ov_n   = n;
            ov_spk = m_bus.out_spikes;
         end
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      m_bus.cfg_valid = 1'b0;
      check("cfg_ready_cycle", 32'(n),      32'd11);
      check("cfg_ov_cycle",    32'(ov_n),   32'd10);
      check("cfg_old_thr",     32'(ov_spk), 32'd3);
      m_step(8'h00, outs, lat);
      check("cfg_new_thr", 32'(outs), 32'd0);

      // Config write and step accept in the same cycle: new thr applies
      m_idle();
      m_bus.cfg_valid = 1'b1;
      m_bus.cfg_addr  = 5'd16;
      m_bus.cfg_data  = 8'hFB;
      m_bus.step      = 1'b1;
      @(posedge clk); #1;
      m_bus.cfg_valid = 1'b0;
      m_bus.step      = 1'b0;
      lat = 1;
      while (!m_bus.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("same_cycle_spikes", 32'(m_bus.out_spikes), 32'd3);
      check("same_cycle_lat",    32'(lat),              32'd10);

      // 3x4 build: addr 0..11 weights, 12 thr, 13 leak_sh, 14 refrac
      s_cfg(4'd0, 8'h08); s_cfg(4'd1, 8'h08); s_cfg(4'd2, 8'h08);
      s_cfg(4'd11, 8'h07); s_cfg(4'd13, 8'd7);
      // n0: -24,-47,-70,-93,-116,-128,-128 ; n3: 7,14,21,28,35(fire),7,14
      s_exp[0] = 4'b0000; s_exp[1] = 4'b0000; s_exp[2] = 4'b0000; s_exp[3] = 4'b0000;
      s_exp[4] = 4'b1000; s_exp[5] = 4'b0000; s_exp[6] = 4'b0000;
      for (int k = 0; k < 7; k++) begin
         s_step(3'b111, souts, lat);
         check($sformatf("small%0d_spikes", k), 32'(souts), 32'(s_exp[k]));
         check($sformatf("small%0d_lat", k),    32'(lat),   32'd5);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
